// File: rtl/uart_frame_ctrl_pkg.sv
// Shared definitions for the UART frame sequencer: state encoding,
// default sync word and the inter-byte timeout calculation.
package uart_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_DATA    = 3'd2,
        ST_CSUM_HI = 3'd3,
        ST_CSUM_LO = 3'd4
    } state_t;

    localparam logic [15:0] DEFAULT_HEADER = 16'hAA55;

    // Gap limit in clock cycles; one byte time is 10 bit times on the line.
    // Computed in 64 bits because the intermediate product exceeds 2^31.
    function automatic int to_cycles(input int timeout_bytes, input int clk_freq,
                                     input int baud_rate);
        longint prod;
        prod = longint'(timeout_bytes) * 64'sd10 * longint'(clk_freq);
        return int'(prod / longint'(baud_rate));
    endfunction

endpackage

// File: rtl/uart_frame_ctrl_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while a frame is in progress
// and pulses expired on the cycle the limit is reached without a new byte.
module uart_frame_ctrl_gap_timer #(
    parameter int TO_CYCLES = 34722
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TO_CYCLES + 1);

    logic [CW-1:0] cnt;

    // A byte in the same cycle as the limit suppresses the expiry.
    assign expired = enable && !clear && (cnt == CW'(TO_CYCLES - 1));

    // Gap counter: held at zero outside a frame, restarted by every byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || clear || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame sequencer behind the byte-level UART receiver: hunts for the sync
// word, collects payload and checksum, and publishes the payload with status.
module uart_frame_ctrl
    import uart_frame_ctrl_pkg::*;
#(
    parameter int          CLK_FREQ      = 100_000_000,
    parameter int          BAUD_RATE     = 115_200,
    parameter logic [15:0] HEADER        = DEFAULT_HEADER,
    parameter int          PAYLOAD_BYTES = 16,
    parameter int          TIMEOUT_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_frame_err,
    output logic                       frame_valid,
    output logic [8*PAYLOAD_BYTES-1:0] frame_data,
    output logic                       frame_ok,
    output logic                       err_timeout,
    output logic                       err_framing,
    output logic                       busy
);

    localparam int TO_CYCLES = to_cycles(TIMEOUT_BYTES, CLK_FREQ, BAUD_RATE);
    localparam int PW        = 8 * PAYLOAD_BYTES;
    localparam int CNT_W     = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [PW-1:0]    payload;
    logic [15:0]      sum;
    logic [7:0]       csum_hi;
    logic             expired;

    assign busy = (state != ST_IDLE);

    uart_frame_ctrl_gap_timer #(
        .TO_CYCLES (TO_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (busy),
        .clear   (rx_valid),
        .expired (expired)
    );

    // Frame FSM with payload shift register, checksum accumulator and
    // registered status pulses; a line error outranks a byte, a byte
    // outranks a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            byte_cnt    <= '0;
            payload     <= '0;
            sum         <= '0;
            csum_hi     <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_ok    <= 1'b0;
            err_timeout <= 1'b0;
            err_framing <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            err_timeout <= 1'b0;
            err_framing <= 1'b0;
            if (rx_frame_err) begin
                // Corrupt byte is dropped; only an in-progress frame reports it.
                if (state != ST_IDLE) begin
                    err_framing <= 1'b1;
                    state       <= ST_IDLE;
                end
            end else if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == HEADER[15:8]) state <= ST_HDR;
                    end
                    ST_HDR: begin
                        if (rx_data == HEADER[7:0]) begin
                            state    <= ST_DATA;
                            byte_cnt <= '0;
                            sum      <= '0;
                        end else if (rx_data != HEADER[15:8]) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        payload  <= {payload[PW-9:0], rx_data};
                        sum      <= sum + {8'h00, rx_data};
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        if (byte_cnt == LAST_BYTE) state <= ST_CSUM_HI;
                    end
                    ST_CSUM_HI: begin
                        csum_hi <= rx_data;
                        state   <= ST_CSUM_LO;
                    end
                    ST_CSUM_LO: begin
                        state       <= ST_IDLE;
                        frame_valid <= 1'b1;
                        frame_data  <= payload;
                        frame_ok    <= ({csum_hi, rx_data} == sum);
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (expired) begin
                err_timeout <= 1'b1;
                state       <= ST_IDLE;
            end
        end
    end

endmodule
